// File: rtl/bus_sched_pkg.sv
// Shared constants, state type and packet helpers for the broadcast-bus round-robin scheduler.
package bus_sched_pkg;

   localparam int DRVRS   = 6;
   localparam int PCKG_SZ = 16;
   localparam int ID_W    = 8;
   localparam int PTR_W   = $clog2(DRVRS);
   localparam logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ROUTE = 2'd2
   } state_e;

   function automatic logic [ID_W-1:0] dest_of(input logic [PCKG_SZ-1:0] packet);
      return packet[PCKG_SZ-1 -: ID_W];
   endfunction

endpackage

// File: rtl/bus_rr_sched_if.sv
// Device-FIFO side of the scheduler: pending flags, show-ahead heads, pop/push strobes and bus data.
interface bus_rr_sched_if;
   import bus_sched_pkg::*;

   logic                     en;
   logic [DRVRS-1:0]         pndng;
   logic [DRVRS*PCKG_SZ-1:0] D_pop;
   logic [DRVRS-1:0]         pop;
   logic [DRVRS-1:0]         push;
   logic [PCKG_SZ-1:0]       D_push;

   modport master (input en, pndng, D_pop, output pop, push, D_push);
   modport slave  (output en, pndng, D_pop, input pop, push, D_push);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping; zero latency.
module rr_pick
   import bus_sched_pkg::*;
(
   input  logic [DRVRS-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] grant,
   output logic             valid
);

   function automatic int wrap(input int v);
      return (v >= DRVRS) ? v - DRVRS : v;
   endfunction

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int k = DRVRS - 1; k >= 0; k--) begin
         if (req[wrap(int'(ptr) + k)]) begin
            grant = PTR_W'(wrap(int'(ptr) + k));
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin bus scheduler: pop one packet per grant, route it unicast/broadcast; pop at N+1, push at N+2.
// No backpressure from destinations; en low only blocks new grants, an in-flight packet always completes.
module bus_rr_sched
   import bus_sched_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   bus_rr_sched_if.master   bus,
   output logic [PTR_W-1:0] grant_id,
   output logic             busy,
   output logic [15:0]      pkt_cnt,
   output logic [7:0]       drop_cnt
);

   state_e             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   sel;
   logic [PTR_W-1:0]   pick_id;
   logic               pick_vld;
   logic               start;
   logic [PCKG_SZ-1:0] pkt;
   logic [PCKG_SZ-1:0] d_push_q;
   logic [PCKG_SZ-1:0] head_dat;
   logic [ID_W-1:0]    dest;
   logic [DRVRS-1:0]   route_mask;
   logic               deliver;

   rr_pick u_pick (
      .req   (bus.pndng),
      .ptr   (rr_ptr),
      .grant (pick_id),
      .valid (pick_vld)
   );

   assign start = bus.en && pick_vld;
   assign dest  = dest_of(pkt);

   always_comb begin
      head_dat = '0;
      for (int i = 0; i < DRVRS; i++) begin
         if (sel == PTR_W'(i)) head_dat = bus.D_pop[i*PCKG_SZ +: PCKG_SZ];
      end
   end

   // The source never receives its own packet, broadcast included.
   always_comb begin
      route_mask = '0;
      for (int i = 0; i < DRVRS; i++) begin
         if (dest == BROADCAST) route_mask[i] = (sel != PTR_W'(i));
         else                   route_mask[i] = (dest == ID_W'(i)) && (sel != PTR_W'(i));
      end
   end

   assign deliver = (state == ROUTE) && (route_mask != '0);

   always_comb begin
      bus.pop = '0;
      if (state == GRANT) bus.pop[sel] = 1'b1;
   end

   assign bus.push   = deliver ? route_mask : '0;
   assign bus.D_push = deliver ? pkt : d_push_q;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         sel      <= '0;
         grant_id <= '0;
         pkt      <= '0;
         d_push_q <= '0;
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= GRANT;
                  sel   <= pick_id;
               end
            end
            GRANT: begin
               grant_id <= sel;
               pkt      <= head_dat;
               rr_ptr   <= (sel == PTR_W'(DRVRS - 1)) ? '0 : sel + 1'b1;
               state    <= ROUTE;
            end
            ROUTE: begin
               if (deliver) begin
                  d_push_q <= pkt;
                  pkt_cnt  <= pkt_cnt + 1'b1;
               end else if (drop_cnt != 8'hFF) begin
                  drop_cnt <= drop_cnt + 1'b1;
               end
               if (start) begin
                  state <= GRANT;
                  sel   <= pick_id;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_rr_sched.sv
// Bench for bus_rr_sched: per-device packet queues feed the DUT, a transaction-level model predicts every cycle.
module tb_bus_rr_sched;
   import bus_sched_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bus_rr_sched_if bus ();
   logic [PTR_W-1:0] grant_id;
   logic             busy;
   logic [15:0]      pkt_cnt;
   logic [7:0]       drop_cnt;

   bus_rr_sched dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .grant_id (grant_id),
      .busy     (busy),
      .pkt_cnt  (pkt_cnt),
      .drop_cnt (drop_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [PCKG_SZ-1:0] q [DRVRS][$];
   bit                 en_drv;

   int                 m_ptr, m_gid, m_pkt, m_drop;
   logic [PCKG_SZ-1:0] m_dpush;
   bit                 pop_prev, pending_pop, en_prev;
   int                 pop_src, pending_src;
   logic [PCKG_SZ-1:0] pop_pkt;
   logic [DRVRS-1:0]   pndng_prev;

   function automatic int rr_winner(input logic [DRVRS-1:0] p, input int ptr);
      for (int k = 0; k < DRVRS; k++) begin
         if (p[(ptr + k) % DRVRS]) return (ptr + k) % DRVRS;
      end
      return 0;
   endfunction

   function automatic int first_set(input logic [DRVRS-1:0] v);
      for (int i = 0; i < DRVRS; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic drive_inputs();
      logic [DRVRS-1:0]         p;
      logic [DRVRS*PCKG_SZ-1:0] d;
      p = '0;
      d = '0;
      for (int i = 0; i < DRVRS; i++) begin
         if (q[i].size() != 0) begin
            p[i] = 1'b1;
            d[i*PCKG_SZ +: PCKG_SZ] = q[i][0];
         end
      end
      bus.en    = en_drv;
      bus.pndng = p;
      bus.D_pop = d;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_gid = 0; m_pkt = 0; m_drop = 0; m_dpush = '0;
      pop_prev = 0; pending_pop = 0; pop_src = 0; pop_pkt = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < DRVRS; i++) q[i].delete();
      model_reset();
      en_drv = 1'b1;
      drive_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // One clock: retire the FIFO pop of the last grant, then compare every output with the model.
   task automatic advance();
      logic [DRVRS-1:0]   exp_pop_vec, exp_push;
      logic [ID_W-1:0]    dst;
      logic [PCKG_SZ-1:0] tmp;
      bit                 exp_pop;
      int                 w;
      pndng_prev = bus.pndng;
      en_prev    = bus.en;
      @(posedge clk);
      #1;
      if (pending_pop) begin
         if (q[pending_src].size() != 0) tmp = q[pending_src].pop_front();
         pending_pop = 0;
      end
      drive_inputs();
      #1;
      exp_pop     = !pop_prev && en_prev && (pndng_prev != '0);
      exp_pop_vec = '0;
      w           = 0;
      if (exp_pop) begin
         w = rr_winner(pndng_prev, m_ptr);
         exp_pop_vec[w] = 1'b1;
      end
      exp_push = '0;
      if (pop_prev) begin
         dst = pop_pkt[PCKG_SZ-1 -: ID_W];
         if (dst == BROADCAST) begin
            exp_push = '1;
            exp_push[pop_src] = 1'b0;
         end else if (dst < DRVRS && int'(dst) != pop_src) begin
            exp_push[dst] = 1'b1;
         end
         if (exp_push != '0) m_dpush = pop_pkt;
      end
      n_checks++; if (bus.pop !== exp_pop_vec) $display("FAIL pop t=%0t got %b exp %b", $time, bus.pop, exp_pop_vec); else n_pass++;
      n_checks++; if (bus.push !== exp_push) $display("FAIL push t=%0t got %b exp %b", $time, bus.push, exp_push); else n_pass++;
      n_checks++; if (bus.D_push !== m_dpush) $display("FAIL D_push t=%0t got %h exp %h", $time, bus.D_push, m_dpush); else n_pass++;
      n_checks++; if (busy !== (exp_pop || pop_prev)) $display("FAIL busy t=%0t got %b exp %b", $time, busy, exp_pop || pop_prev); else n_pass++;
      n_checks++; if (grant_id !== PTR_W'(m_gid)) $display("FAIL grant_id t=%0t got %0d exp %0d", $time, grant_id, m_gid); else n_pass++;
      n_checks++; if (pkt_cnt !== 16'(m_pkt)) $display("FAIL pkt_cnt t=%0t got %0d exp %0d", $time, pkt_cnt, m_pkt); else n_pass++;
      n_checks++; if (drop_cnt !== 8'(m_drop)) $display("FAIL drop_cnt t=%0t got %0d exp %0d", $time, drop_cnt, m_drop); else n_pass++;
      if (pop_prev) begin
         if (exp_push != '0) m_pkt = (m_pkt + 1) % 65536;
         else if (m_drop < 255) m_drop++;
      end
      if (exp_pop) begin
         m_gid       = w;
         m_ptr       = (w + 1) % DRVRS;
         pending_pop = 1;
         pending_src = w;
         pop_src     = w;
         pop_pkt     = (q[w].size() != 0) ? q[w][0] : '0;
      end
      pop_prev = exp_pop;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0;
      #2;
      n_checks++; if ({bus.pop, bus.push} !== '0) $display("FAIL reset_strobes got %b exp 0", {bus.pop, bus.push}); else n_pass++;
      n_checks++; if ({bus.D_push, grant_id, busy} !== '0) $display("FAIL reset_state got %h exp 0", {bus.D_push, grant_id, busy}); else n_pass++;
      n_checks++; if ({pkt_cnt, drop_cnt} !== '0) $display("FAIL reset_counters got %h exp 0", {pkt_cnt, drop_cnt}); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_unicast();
      do_reset();
      q[2].push_back(16'h0401);
      drive_inputs();
      advance();
      n_checks++; if (bus.pop !== 6'b000100) $display("FAIL uni_pop got %b exp 000100", bus.pop); else n_pass++;
      advance();
      n_checks++; if (bus.push !== 6'b010000 || bus.D_push !== 16'h0401) $display("FAIL uni_push got %b/%h exp 010000/0401", bus.push, bus.D_push); else n_pass++;
      advance();
      n_checks++; if (pkt_cnt !== 16'd1 || grant_id !== 3'd2) $display("FAIL uni_status got %0d/%0d exp 1/2", pkt_cnt, grant_id); else n_pass++;
   endtask

   task automatic test_broadcast();
      logic [DRVRS-1:0]   seen_push;
      logic [PCKG_SZ-1:0] seen_dat;
      do_reset();
      q[1].push_back(16'hFF55);
      drive_inputs();
      seen_push = '0;
      seen_dat  = '0;
      repeat (4) begin
         advance();
         if (bus.push != '0) begin seen_push = bus.push; seen_dat = bus.D_push; end
      end
      n_checks++; if (seen_push !== 6'b111101 || seen_dat !== 16'hFF55) $display("FAIL bcast got %b/%h exp 111101/ff55", seen_push, seen_dat); else n_pass++;
      n_checks++; if (drop_cnt !== 8'd0 || pkt_cnt !== 16'd1) $display("FAIL bcast_cnt got %0d/%0d exp 0/1", drop_cnt, pkt_cnt); else n_pass++;
   endtask

   task automatic test_fairness();
      int exp_seq [7] = '{0, 1, 2, 3, 4, 5, 0};
      int seq [$];
      int pops12;
      do_reset();
      for (int i = 0; i < DRVRS; i++)
         for (int k = 0; k < 3; k++)
            q[i].push_back((i == 0) ? 16'(16'h0100 + k) : 16'((i << 4) + k));
      drive_inputs();
      pops12 = 0;
      for (int c = 0; c < 13; c++) begin
         advance();
         if (bus.pop != '0) begin
            seq.push_back(first_set(bus.pop));
            if (c < 12) pops12++;
         end
      end
      n_checks++; if (pops12 != 6) $display("FAIL fair_rate got %0d exp 6", pops12); else n_pass++;
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (i >= seq.size()) $display("FAIL fair_seq[%0d] got none exp %0d", i, exp_seq[i]);
         else if (seq[i] != exp_seq[i]) $display("FAIL fair_seq[%0d] got %0d exp %0d", i, seq[i], exp_seq[i]);
         else n_pass++;
      end
   endtask

   task automatic test_drops();
      logic [DRVRS-1:0] any_push;
      do_reset();
      q[3].push_back(16'h0300);
      q[3].push_back(16'h0900);
      drive_inputs();
      any_push = '0;
      repeat (8) begin advance(); any_push |= bus.push; end
      n_checks++; if (drop_cnt !== 8'd2 || any_push !== '0) $display("FAIL drop_two got %0d/%b exp 2/000000", drop_cnt, any_push); else n_pass++;
      for (int k = 0; k < 300; k++) q[2].push_back(16'h0200);
      drive_inputs();
      repeat (620) begin advance(); any_push |= bus.push; end
      n_checks++; if (drop_cnt !== 8'hFF || pkt_cnt !== 16'd0 || any_push !== '0) $display("FAIL drop_sat got %0d/%0d/%b exp 255/0/000000", drop_cnt, pkt_cnt, any_push); else n_pass++;
   endtask

   task automatic test_en_gating();
      int pops;
      do_reset();
      q[1].push_back(16'h0005);
      q[1].push_back(16'h0006);
      drive_inputs();
      advance();
      n_checks++; if (bus.pop !== 6'b000010) $display("FAIL en_grant got %b exp 000010", bus.pop); else n_pass++;
      en_drv = 1'b0;
      drive_inputs();
      advance();
      n_checks++; if (bus.push !== 6'b000001) $display("FAIL en_route got %b exp 000001", bus.push); else n_pass++;
      pops = 0;
      repeat (5) begin advance(); if (bus.pop != '0) pops++; end
      n_checks++; if (pops != 0 || busy !== 1'b0) $display("FAIL en_idle got pops=%0d busy=%b exp 0/0", pops, busy); else n_pass++;
      en_drv = 1'b1;
      drive_inputs();
      advance();
      n_checks++; if (bus.pop !== 6'b000010) $display("FAIL en_resume got %b exp 000010", bus.pop); else n_pass++;
      advance();
   endtask

   task automatic test_async_reset();
      logic [PCKG_SZ-1:0] tmp;
      do_reset();
      q[3].push_back(16'h0100);
      drive_inputs();
      advance();
      n_checks++; if (bus.pop !== 6'b001000) $display("FAIL ar_grant got %b exp 001000", bus.pop); else n_pass++;
      @(posedge clk);
      #1;
      tmp = q[3].pop_front();
      drive_inputs();
      #1;
      reset = 1'b0;
      #1;
      n_checks++; if (bus.push !== '0 || busy !== 1'b0) $display("FAIL ar_abort got %b/%b exp 000000/0", bus.push, busy); else n_pass++;
      n_checks++; if (grant_id !== '0 || pkt_cnt !== '0 || bus.D_push !== '0) $display("FAIL ar_clear got %0d/%0d/%h exp 0/0/0", grant_id, pkt_cnt, bus.D_push); else n_pass++;
      model_reset();
      q[0].push_back(16'h0300);
      q[4].push_back(16'h0000);
      drive_inputs();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      advance();
      n_checks++; if (bus.pop !== 6'b000001) $display("FAIL ar_restart got %b exp 000001", bus.pop); else n_pass++;
      advance();
      n_checks++; if (bus.push !== 6'b001000) $display("FAIL ar_push got %b exp 001000", bus.push); else n_pass++;
      repeat (4) advance();
   endtask

   task automatic test_random();
      int r;
      logic [ID_W-1:0] dst;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, DRVRS - 1);
            if (q[r].size() < 4) begin
               case ($urandom_range(0, 9))
                  6:       dst = BROADCAST;
                  7:       dst = 8'($urandom_range(DRVRS, 254));
                  default: dst = 8'($urandom_range(0, DRVRS - 1));
               endcase
               q[r].push_back({dst, 8'($urandom_range(0, 255))});
            end
         end
         en_drv = ($urandom_range(0, 9) != 0);
         drive_inputs();
         advance();
      end
      en_drv = 1'b1;
      drive_inputs();
   endtask

   initial begin
      reset  = 1'b0;
      en_drv = 1'b0;
      model_reset();
      drive_inputs();
      test_reset();
      test_unicast();
      test_broadcast();
      test_fairness();
      test_drops();
      test_en_gating();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_rr_sched.md
Name: bus_rr_sched

Overview:
Round-robin scheduler that shares the single broadcast bus among drvrs device FIFOs.
- Watches each device's pending flag and pops one packet from the winning device.
- Decodes the destination field and pushes the packet to one device or to all other devices (broadcast).
- Sits between the per-device FIFOs and the bus generator, sequencing all bus traffic; targets the bits=1 bus configuration.

Parameters:
drvrs, 6, number of devices on the bus
pckg_sz, 16, packet width in bits
id_w, 8, destination field width; field is D[pckg_sz-1 -: id_w]
broadcast, {8{1'b1}}, destination value meaning "all devices except source"

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  scheduler enable; low blocks new grants only
pndng  in  drvrs  device i FIFO non-empty
D_pop  in  drvrs*pckg_sz  show-ahead head data of FIFO i, slice [i*pckg_sz +: pckg_sz]
pop  out  drvrs  one-hot, one-cycle pop strobe to the granted FIFO
push  out  drvrs  one-cycle push strobe(s) to destination FIFO(s)
D_push  out  pckg_sz  packet on the bus, shared by all destinations
grant_id  out  $clog2(drvrs)  index of the last granted device
busy  out  1  high in GRANT and ROUTE states
pkt_cnt  out  16  delivered packets, wraps at 0xFFFF
drop_cnt  out  8  dropped packets, saturates at 0xFF

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; pop, push, D_push, grant_id, pkt_cnt and drop_cnt all 0; busy=0.
  - Round-robin pointer rr_ptr=0.
- Reset asserted mid-transaction aborts it: no push is issued, and the popped packet is lost. This is accepted behaviour.
- FSM states: IDLE, GRANT, ROUTE.
- IDLE:
  - If en=1 and pndng!=0, go to GRANT next cycle.
  - The winner is the first set pndng bit searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., drvrs-1, 0, ...).
- GRANT (1 cycle):
  - pop[w]=1 (one-hot); grant_id<=w.
  - Capture D_pop slice w into the packet register; rr_ptr<=(w+1) mod drvrs.
  - Next state is ROUTE.
- ROUTE (1 cycle). With dest = packet[pckg_sz-1 -: id_w]:
  - dest==broadcast: push[i]=1 for every i!=w; D_push=packet; pkt_cnt+1.
  - dest<drvrs and dest!=w: push[dest]=1; D_push=packet; pkt_cnt+1.
  - Otherwise (dest out of range or self-addressed): no push; drop_cnt+1, saturating at 0xFF.
  - Next state: GRANT if en=1 and any pndng is set; else IDLE. pndng of the just-popped device is re-sampled and counts if still set.
- Latency: pndng rising in IDLE at edge N gives pop at N+1 and push at N+2. Sustained throughput is 1 packet per 2 cycles.
- pop and push are never both high for the same device in the same cycle, except push to the source in a broadcast, which is excluded.
- D_push holds its value until the next delivering ROUTE.
- en falling during GRANT or ROUTE: the current packet completes, then the FSM goes to IDLE.
- pndng deasserting in the GRANT cycle itself is a protocol violation by the FIFO; the pop is still issued.
- The scheduler pushes unconditionally and does not model destination FIFO full.

Decomposition:
- Package bus_sched_pkg:
  - State enum (IDLE, GRANT, ROUTE).
  - Function dest_of(packet) returning the id_w-bit destination field.
  - Localparam PTR_W=$clog2(drvrs).
- Sub-module rr_pick, purely combinational: inputs req[drvrs] and ptr; outputs grant index and valid. It is instantiated once by bus_rr_sched.

Test Plan:
- Single unicast: pndng=6'b000100, D_pop[2]=16'h0401, en=1 → pop=6'b000100 at N+1; push=6'b010000 with D_push=16'h0401 at N+2; pkt_cnt=1; grant_id=2.
- Broadcast: device 1 holds 16'hFF55 → push=6'b111101 (all except bit 1) with D_push=16'hFF55; drop_cnt stays 0.
- Fairness: pndng=6'b111111 held constant, each device's packet addressed to device 0, except device 0's packet addressed to device 1 → grant_id sequence 0,1,2,3,4,5,0; exactly 6 pops per 12 cycles.
- Drops: device 3 sends 16'h0300 (self) then 16'h0900 (out of range) → no push for either; drop_cnt=2. Then 300 bad packets → drop_cnt holds at 0xFF.
- en gating: drop en during GRANT → ROUTE completes and push is issued, then the FSM idles with pndng still high. No pop occurs until en=1.
- Async reset: assert reset=0 between GRANT and ROUTE → outputs clear immediately without waiting for a clock edge; no push follows. After release, the next grant starts from device 0.
